// File: rtl/csel_div_pkg.sv
// csel_div_pkg
// Shared types and constants for the carry-select sequential divider.
//   state_t      : divider FSM states (IDLE / CALC / DONE)
//   DEF_WIDTH    : default operand/result width
//   DEF_BLOCK    : default carry-select block width in the subtractor
//   DEF_CNT_W    : iteration counter width for the default operand width
package csel_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

endpackage

// File: rtl/csel_seq_divider_if.sv
// csel_seq_divider_if
// Request/response bundle of the sequential divider.
//   in_valid/in_ready     : request handshake; dividend, divisor travel with it
//   out_valid/out_ready   : response handshake; quotient, remainder, div_by_zero
//   modport slave         : divider side
//   modport master        : requester side
interface csel_seq_divider_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/csel_seq_divider_subtractor.sv
// csel_subtractor
// Combinational carry-select subtractor: diff = a - b computed as a + ~b + 1.
// The lowest block ripples with carry-in 1; every upper block precomputes
// its sum for carry-in 0 and 1 and selects with the incoming block carry.
//   a, b    : WIDTH-bit unsigned operands
//   diff    : WIDTH-bit difference (modulo 2^WIDTH)
//   borrow  : 1 when a < b (inverse of the final carry out)
module csel_subtractor #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] nb_s;
  logic [NBLK:0]    carry_s;

  assign nb_s       = ~b;
  assign carry_s[0] = 1'b1;

  genvar g;
  for (g = 0; g < NBLK; g++) begin : g_blk
    if (g == 0) begin : g_ripple
      logic [BLOCK:0] sum_s;
      assign sum_s = {1'b0, a[BLOCK-1:0]} + {1'b0, nb_s[BLOCK-1:0]}
                   + {{BLOCK{1'b0}}, carry_s[0]};
      assign diff[BLOCK-1:0] = sum_s[BLOCK-1:0];
      assign carry_s[1]      = sum_s[BLOCK];
    end else begin : g_select
      logic [BLOCK:0] sum0_s;
      logic [BLOCK:0] sum1_s;
      assign sum0_s = {1'b0, a[g*BLOCK +: BLOCK]} + {1'b0, nb_s[g*BLOCK +: BLOCK]};
      assign sum1_s = {1'b0, a[g*BLOCK +: BLOCK]} + {1'b0, nb_s[g*BLOCK +: BLOCK]}
                    + {{BLOCK{1'b0}}, 1'b1};
      assign diff[g*BLOCK +: BLOCK] = carry_s[g] ? sum1_s[BLOCK-1:0] : sum0_s[BLOCK-1:0];
      assign carry_s[g+1]           = carry_s[g] ? sum1_s[BLOCK] : sum0_s[BLOCK];
    end
  end

  assign borrow = ~carry_s[NBLK];

endmodule

// File: rtl/csel_seq_divider.sv
// csel_seq_divider
// Restoring unsigned divider, one quotient bit per cycle, trial subtraction
// on a carry-select subtractor. One operation in flight.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : csel_seq_divider_if.slave (request and response handshakes)
// Optional feature macro DIV_ZERO_FAST_EN: a zero divisor skips the
// iterations and completes in a single edge with the same result values.
module csel_seq_divider
  import csel_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic                clk,
  input  logic                rst,
  csel_seq_divider_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dz_r;

  logic [WIDTH:0]   s_s;
  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic             ok_s;
  logic             accept_s;
  logic             div_zero_s;

  // Partial remainder shifted left with the next dividend bit.
  assign s_s = {r_r, q_r[WIDTH-1]};

  csel_subtractor #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) u_sub (
    .a      (s_s[WIDTH-1:0]),
    .b      (d_r),
    .diff   (diff_s),
    .borrow (borrow_s)
  );

  // A set bit shifted out of R means S exceeds any WIDTH-bit divisor.
  assign ok_s       = s_s[WIDTH] | ~borrow_s;
  assign accept_s   = (state_r == IDLE) & bus.in_valid;
  assign div_zero_s = (bus.divisor == {WIDTH{1'b0}});

  assign bus.in_ready    = (state_r == IDLE);
  assign bus.out_valid   = (state_r == DONE);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dz_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef DIV_ZERO_FAST_EN
          if (div_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
`else
          state_s = CALC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= {WIDTH{1'b0}};
      r_r   <= {WIDTH{1'b0}};
      d_r   <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      dz_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            q_r   <= bus.dividend;
            r_r   <= {WIDTH{1'b0}};
            d_r   <= bus.divisor;
            cnt_r <= {CNT_W{1'b0}};
            dz_r  <= div_zero_s;
`ifdef DIV_ZERO_FAST_EN
            // Result the full iteration would have produced for a zero divisor.
            if (div_zero_s) begin
              q_r <= {WIDTH{1'b1}};
              r_r <= bus.dividend;
            end
`endif
          end
        end
        CALC: begin
          r_r   <= ok_s ? diff_s : s_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], ok_s};
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          q_r <= q_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csel_seq_divider.sv
// tb_csel_seq_divider
// Self-checking bench: directed cases for the documented corner behaviour,
// then randomised back-to-back traffic with random response backpressure,
// checked against a plain-arithmetic reference model.
module tb_csel_seq_divider;

  localparam int W = 16;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  csel_seq_divider_if #(.WIDTH(W)) bus ();

  csel_seq_divider #(.WIDTH(W), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic logic [32:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return {1'b1, 16'hFFFF, a};
    else            return {1'b0, a / b, a % b};
  endfunction

  // Present a request and return just after the accepting edge (edge 0).
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int w;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) check_eq("accept_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz,
                       input int elat);
    int lat;
    issue(a, b);
    check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_q"},   32'(bus.quotient),    32'(eq));
    check_eq({tag, "_r"},   32'(bus.remainder),   32'(er));
    check_eq({tag, "_dz"},  32'(bus.div_by_zero), 32'(edz));
    @(posedge clk); #1;
    check_eq({tag, "_idle"},  32'(bus.in_ready),  32'd1);
    check_eq({tag, "_vlow"},  32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int sent, recv, cyc;

    bus.in_valid  = 1'b0;
    bus.dividend  = 16'd0;
    bus.divisor   = 16'd0;
    bus.out_ready = 1'b1;

    // Reset state, with a request presented during reset that must be ignored.
    #1 rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 16'd9;
    bus.divisor  = 16'd3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check_eq("rst_quotient",  32'(bus.quotient),    32'd0);
    check_eq("rst_remainder", 32'(bus.remainder),   32'd0);
    check_eq("rst_dz",        32'(bus.div_by_zero), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready),    32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_idle", 32'(bus.in_ready), 32'd1);

    // Directed arithmetic cases.
    do_op("d100_7",   16'd100,   16'd7,  16'd14,    16'd2,     1'b0, W);
    do_op("dffff_1",  16'hFFFF,  16'd1,  16'hFFFF,  16'd0,     1'b0, W);
    do_op("d5_9",     16'd5,     16'd9,  16'd0,     16'd5,     1'b0, W);
    do_op("d1234_0",  16'h1234,  16'd0,  16'hFFFF,  16'h1234,  1'b1, ZLAT);
    do_op("dmax_max", 16'hFFFF,  16'hFFFF, 16'd1,   16'd0,     1'b0, W);

    // Backpressure: result held for 5 cycles with out_ready low.
    bus.out_ready = 1'b0;
    issue(16'd1000, 16'd3);
    wait_valid(lat);
    check_eq("bp_lat", 32'(lat), 32'(W));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_ready", 32'(bus.in_ready),  32'd0);
      check_eq("bp_q",     32'(bus.quotient),  32'd333);
      check_eq("bp_r",     32'(bus.remainder), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_idle",  32'(bus.in_ready),  32'd1);
    check_eq("bp_release_vlow",  32'(bus.out_valid), 32'd0);

    // Reset during iteration 7 abandons the operation.
    issue(16'hABCD, 16'd3);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(bus.out_valid),   32'd0);
    check_eq("midrst_q",     32'(bus.quotient),    32'd0);
    check_eq("midrst_r",     32'(bus.remainder),   32'd0);
    check_eq("midrst_dz",    32'(bus.div_by_zero), 32'd0);
    check_eq("midrst_ready", 32'(bus.in_ready),    32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) check_eq("midrst_ghost", 32'(bus.out_valid), 32'd0);
    end
    do_op("d60000_250", 16'd60000, 16'd250, 16'd240, 16'd0, 1'b0, W);

    // Randomised back-to-back traffic with random out_ready.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (sent < 1000) begin
        bus.in_valid = ($urandom_range(9, 0) < 8);
        bus.dividend = 16'($urandom);
        case ($urandom_range(15, 0))
          0:       bus.divisor = 16'd0;
          1, 2, 3: bus.divisor = 16'($urandom_range(15, 1));
          default: bus.divisor = 16'($urandom);
        endcase
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_div(bus.dividend, bus.divisor));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check_eq("rand_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rand_q",  32'(bus.quotient),    32'(e[31:16]));
          check_eq("rand_r",  32'(bus.remainder),   32'(e[15:0]));
          check_eq("rand_dz", 32'(bus.div_by_zero), 32'(e[32]));
        end
        recv++;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("rand_recv_count", 32'(recv), 32'd1000);
    check_eq("rand_sent_count", 32'(sent), 32'd1000);
    check_eq("rand_leftover",   32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csel_seq_divider.md
# csel_seq_divider

Sequential unsigned integer divider: the subtractive counterpart of the team's carry-select adder datapath. It computes quotient and remainder one bit per cycle, restoring algorithm, with each trial subtraction done on a carry-select subtractor. It sits behind a valid/ready request port and a valid/ready response port, one operation in flight.

## Interface
- WIDTH, 16, operand/result width; multiple of BLOCK, ≥ 8
- BLOCK, 4, carry-select block width inside the subtractor
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid
- dividend  in  WIDTH  unsigned dividend
- divisor  in  WIDTH  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when high with out_valid
- quotient  out  WIDTH  unsigned quotient
- remainder  out  WIDTH  unsigned remainder
- div_by_zero  out  1  divisor was zero for this result

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- in_ready = (state == IDLE), combinational. Requests seen while rst is high are ignored.
- IDLE:
  - on in_valid & in_ready, capture dividend into the Q shift register and divisor into D.
  - clear R (WIDTH bits) and the iteration counter; latch dz = (divisor == 0); go to CALC.
- CALC, per cycle:
  - S = {R, Q[MSB]} (WIDTH+1 bits).
  - diff/borrow = S[WIDTH-1:0] − D, computed as A + ~B + 1 on the carry-select subtractor.
  - ok = S[WIDTH] | ~borrow.
  - R ← ok ? diff : S[WIDTH-1:0]; Q ← {Q[WIDTH-2:0], ok}.
  - After WIDTH iterations → DONE.
- DONE:
  - out_valid = 1; quotient = Q, remainder = R, div_by_zero = dz.
  - All held stable until out_ready; on out_valid & out_ready → IDLE.
- Divide by zero on the normal path naturally yields quotient = all ones, remainder = dividend.
- R always < D after each ok step; no overflow beyond WIDTH bits.

## Timing
- Reset values: out_valid 0, quotient 0, remainder 0, div_by_zero 0, in_ready 1 (state IDLE).
- Acceptance edge = edge 0. out_valid rises after edge WIDTH (16 cycles at default).
- Response handshake at edge k → in_ready high after edge k; next accept no earlier than edge k+1.
- No same-cycle accept during DONE.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- rst asserted mid-CALC or mid-DONE:
  - immediately abandons the operation and forces all reset values.
  - no result is emitted for the abandoned request.
- Counter wraps exactly at WIDTH−1 → DONE; never counts past.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - a request with divisor == 0 goes IDLE → DONE in one edge.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - out_valid is high after edge 1.
- Undefined:
  - zero divisor runs the full WIDTH iterations, giving identical result values.
  - div_by_zero is still reported; only latency differs.

## Structure
- Package csel_div_pkg holds:
  - state enum type (IDLE/CALC/DONE);
  - default WIDTH/BLOCK constants;
  - counter width constant $clog2(WIDTH).
- Sub-module csel_subtractor (WIDTH, BLOCK), purely combinational:
  - first block ripples with carry-in 1;
  - upper blocks precompute both carry cases and mux;
  - outputs diff and borrow = ~carry_out.

## Test plan
- 100 / 7 → quotient 14, remainder 2, div_by_zero 0, out_valid exactly 16 cycles after accept.
- 0xFFFF / 0x0001 → quotient 0xFFFF, remainder 0; 5 / 9 → quotient 0, remainder 5.
- 0x1234 / 0 → quotient 0xFFFF, remainder 0x1234, div_by_zero 1; latency 1 with DIV_ZERO_FAST_EN, 16 without.
- out_ready held low 5 cycles in DONE:
  - outputs stable, in_ready 0 throughout;
  - release → IDLE next edge.
- rst pulse at CALC iteration 7:
  - out_valid 0 and results 0 immediately;
  - new request 60000/250 → 240 rem 0.
- 1000 randomised back-to-back requests with random out_ready → results match the reference model, no drops, no duplicates.
